// File: rtl/bcd_conv_if.sv
// Request/result bundle between the arithmetic blocks and the BCD converter.
// The arithmetic side drives the master modport.
// The converter presents the slave modport.
interface bcd_conv_if #(
  parameter int W = 20,
  parameter int N = 7
);
  logic             s;
  logic [W-1:0]     a;
  logic             busy;
  logic             done;
  logic [4*N-1:0]   d;
  logic [2:0]       nd;

  modport master (output s, output a, input busy, input done, input d, input nd);
  modport slave  (input s, input a, output busy, output done, output d, output nd);
endinterface

// File: rtl/bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// It produces packed BCD digits and a significant-digit count for the display stage.
module bcd_conv #(
  parameter int W = 20,
  parameter int N = 7
) (
  input  logic      t,
  input  logic      c,
  bcd_conv_if.slave bus
);

  localparam int SW = 4*N + W;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d, sr_shift;
  logic [4:0]      i_q, i_d;
  logic [4*N-1:0]  d_q, d_d;
  logic [2:0]      nd_q, nd_d;
  logic            done_q, done_d;
  logic            last;

  // Add 3 to every digit >= 5; all digits judged on the pre-correction value
  function automatic logic [4*N-1:0] add3(input logic [4*N-1:0] bcd);
    logic [4*N-1:0] r;
    r = bcd;
    for (int j = 0; j < N; j++) begin
      if (bcd[4*j +: 4] >= 4'd5) r[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One plus the index of the highest nonzero digit, or 1 when all digits are zero
  function automatic logic [2:0] sig_digits(input logic [4*N-1:0] bcd);
    logic [2:0] n;
    n = 3'd1;
    for (int j = 0; j < N; j++) begin
      if (bcd[4*j +: 4] != 4'd0) n = 3'(j + 1);
    end
    return n;
  endfunction

  // One iteration: correct the BCD digits, then shift the whole register left
  always_comb begin
    sr_shift = {add3(sr_q[SW-1:W]), sr_q[W-1:0]} << 1;
    last     = (state_q == SHIFT) && (i_q == 5'(W - 1));
  end

  // State register and datapath flops, with reset taking priority
  always_ff @(posedge t) begin
    if (c) begin
      state_q <= IDLE;
      sr_q    <= '0;
      i_q     <= '0;
      d_q     <= '0;
      nd_q    <= 3'd1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      i_q     <= i_d;
      d_q     <= d_d;
      nd_q    <= nd_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept a request in IDLE, leave SHIFT after the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.s) state_d = SHIFT;
      SHIFT:   if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, iterate in SHIFT, publish on the last bit
  always_comb begin
    sr_d   = sr_q;
    i_d    = i_q;
    d_d    = d_q;
    nd_d   = nd_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.s) begin
        sr_d = {{(4*N){1'b0}}, bus.a};
        i_d  = '0;
      end
    end else begin
      sr_d = sr_shift;
      i_d  = i_q + 5'd1;
      if (last) begin
        d_d    = sr_shift[SW-1:W];
        nd_d   = sig_digits(sr_shift[SW-1:W]);
        done_d = 1'b1;
      end
    end
  end

  // Outputs come straight from flops
  always_comb begin
    bus.busy = (state_q == SHIFT);
    bus.done = done_q;
    bus.d    = d_q;
    bus.nd   = nd_q;
  end

endmodule

// File: tb/tb_bcd_conv.sv
// Self-checking bench for bcd_conv: directed cases plus a random regression
// checked against a decimal-arithmetic reference model.
module tb_bcd_conv;

  localparam int W = 20;
  localparam int N = 7;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   excl_viol;

  bcd_conv_if #(.W(W), .N(N)) bus ();

  bcd_conv #(.W(W), .N(N)) dut (
    .t   (clk),
    .c   (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done and busy must never be high together
  always @(negedge clk) begin
    if (!rst && bus.done && bus.busy) excl_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digit j of v
  function automatic int digit_of(input int v, input int j);
    int p;
    p = 1;
    for (int k = 0; k < j; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  // Reference: number of decimal digits of v (0 has one digit)
  function automatic int ndig(input int v);
    int n;
    int x;
    n = 1;
    x = v / 10;
    while (x > 0) begin
      n++;
      x = x / 10;
    end
    return n;
  endfunction

  task automatic check_result(input string tag, input int v);
    for (int j = 0; j < N; j++) begin
      chk($sformatf("%s_dig%0d", tag, j), 32'(bus.d[4*j +: 4]), 32'(digit_of(v, j)));
    end
    chk({tag, "_nd"}, 32'(bus.nd), 32'(ndig(v)));
  endtask

  // Wait for done, counting latency and busy cycles; returns in the done cycle
  task automatic wait_done(output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bsy++;
      tick();
      lat++;
    end
  endtask

  // Full conversion: accept on the next edge, scramble a, wait and check
  task automatic run_conv(input int v, input string tag, input bit full);
    int lat;
    int bsy;
    bus.s = 1'b1;
    bus.a = 20'(v);
    tick();
    bus.s = 1'b0;
    bus.a = 20'($urandom);
    wait_done(lat, bsy);
    if (full) begin
      chk({tag, "_lat"}, 32'(lat), 32'd20);
      chk({tag, "_busycyc"}, 32'(bsy), 32'd20);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    end else if (lat != 20) begin
      chk({tag, "_lat"}, 32'(lat), 32'd20);
    end
    check_result(tag, v);
  endtask

  initial begin
    int lat;
    int bsy;
    int seen;
    int v;
    n_cmp = 0;
    n_bad = 0;
    excl_viol = 0;
    rst   = 1'b1;
    bus.s = 1'b0;
    bus.a = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_d",    32'(bus.d),    32'd0);
    chk("rst_nd",   32'(bus.nd),   32'd1);

    // Zero, typical product, all ones, small value
    run_conv(0, "zero", 1'b1);
    chk("zero_dpk", 32'(bus.d), 32'h0000000);
    tick();
    run_conv(72897, "mul", 1'b1);
    chk("mul_dpk", 32'(bus.d), 32'h0072897);
    tick();
    run_conv(1048575, "ones", 1'b1);
    chk("ones_dpk", 32'(bus.d), 32'h1048575);
    tick();
    chk("done_drop", 32'(bus.done), 32'd0);
    chk("d_hold", 32'(bus.d), 32'h1048575);
    run_conv(9, "nine", 1'b1);
    chk("nine_dpk", 32'(bus.d), 32'h0000009);
    tick();

    // Requests while busy are ignored; a request held into done is accepted
    bus.s = 1'b1;
    bus.a = 20'd524;
    tick();
    lat = 0;
    while (!bus.done && lat < 40) begin
      bus.s = (lat == 5 || lat >= 19);
      bus.a = 20'd61;
      tick();
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd20);
    chk("ign_dpk", 32'(bus.d), 32'h0000524);
    chk("ign_nd",  32'(bus.nd), 32'd3);
    chk("ign_s_held", 32'(bus.s), 32'd1);
    tick();
    bus.s = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done(lat, bsy);
    chk("b2b_lat", 32'(lat), 32'd20);
    chk("b2b_dpk", 32'(bus.d), 32'h0000061);
    chk("b2b_nd",  32'(bus.nd), 32'd2);
    tick();

    // Reset in the middle of a conversion
    bus.s = 1'b1;
    bus.a = 20'd999999;
    tick();
    bus.s = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_d",    32'(bus.d),    32'd0);
    chk("abort_nd",   32'(bus.nd),   32'd1);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) seen++;
      tick();
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_conv(100000, "after_abort", 1'b1);
    chk("after_abort_dpk", 32'(bus.d), 32'h0100000);

    // Random regression, back to back
    for (int r = 0; r < 1000; r++) begin
      v = (r % 10 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 1048575));
      run_conv(v, $sformatf("rnd%0d", r), (r % 50 == 0));
    end
    tick();

    chk("done_busy_excl", 32'(excl_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_conv.md
# bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the `mul` and `div` arithmetic blocks. It accepts one 20-bit unsigned result per request (product, quotient or remainder) and runs a double-dabble (shift-add-3) conversion, one bit per clock. It returns seven packed BCD digits plus a significant-digit count for the display stage. It runs in the same `t` clock domain as the arithmetic blocks.

## Interface

**Parameters**
- `W`, default 20: binary input width. Matches the 20-bit datapath of `mul`/`div`.
- `N`, default 7: number of BCD digits. Must satisfy 10^N > 2^W − 1.

**Ports** (name, direction, width, meaning)
- `t`, input, 1: clock. All state changes on posedge `t`.
- `c`, input, 1: reset. Synchronous, active-high. One clock, one synchronous active-high reset.
- `s`, input, 1: start request. Sampled only while idle.
- `a`, input, W: unsigned binary value. Sampled on the accepting edge only.
- `busy`, output, 1: conversion in progress.
- `done`, output, 1: one-cycle pulse. `d`/`nd` are valid from this cycle.
- `d`, output, 4*N: packed BCD. Digit 0 (units) is in `d[3:0]`; digit N−1 is in `d[4N-1:4N-4]`.
- `nd`, output, 3: count of significant digits, 1..N. Value 0 gives `nd = 1`.

## Operation

**State machine: IDLE, SHIFT.**

IDLE:
- When `s` = 1 at posedge: load shift register `{bcd[4N-1:0], bin[W-1:0]} <= {0, a}`, clear iteration counter `i` (5 bits), go to SHIFT, set `busy` = 1.
- When `s` = 0: hold.

SHIFT, one iteration per clock:
- Correction: every 4-bit digit of `bcd` ≥ 5 gets +3. All digits are corrected in parallel from the pre-correction value.
- Then shift the whole `{bcd, bin}` left by 1.
- Increment `i`.
- On the iteration where `i == W−1`:
  - write the post-shift `bcd` to `d`;
  - write the digit count to `nd` = 1 + index of the highest nonzero digit, or 1 if all digits are zero;
  - pulse `done` = 1, clear `busy`, return to IDLE.

Rules:
- `s` is ignored while `busy` = 1. No queueing, no error flag.
- `a` may change freely after the accepting edge. The internal copy is used.
- `d` and `nd` hold their last result until the next `done`. They are not cleared at start.
- Digit correction uses 4-bit add with no carry out. A digit ≤ 7 corrected never exceeds 4 bits.
- No overflow is possible for legal `W`/`N`. All arithmetic is unsigned.
- Reset (`c` = 1) at any edge, including mid-SHIFT, forces the following. Reset has priority over `s`.
  - State IDLE, `i` = 0, shift register = 0.
  - `busy` = 0, `done` = 0, `d` = 0, `nd` = 1.
  - The aborted conversion produces no `done`.

## Timing

- Accepting edge k: `busy` = 1 from after edge k.
- SHIFT iterations occur on edges k+1 .. k+W (W = 20 iterations).
- After edge k+W: `done` = 1, `busy` = 0, `d`/`nd` are new.
- Latency from accept to `done` is exactly W cycles. After edge k+W+1, `done` = 0.
- Back-to-back: `s` = 1 during the `done` cycle is accepted (state is IDLE). Throughput is one conversion per W+1 cycles.
- `done` and `busy` are never both 1.
- Outputs are registered with no combinational path from inputs.
- Reset values: `busy` = 0, `done` = 0, `d` = 0, `nd` = 1.

## Test plan

1. Reset, then `a` = 0, `s` pulse → `done` 20 cycles after accept, `d` = 28'h0000000, `nd` = 1.
2. `a` = 72897 (mul output for 517*141) → `d` = 28'h0072897, `nd` = 5. Check `busy` is high for exactly 20 cycles.
3. `a` = 1048575 (all ones) → `d` = 28'h1048575, `nd` = 7. Then `a` = 9 → `d` = 28'h0000009, `nd` = 1.
4. Accept `a` = 524. Pulse `s` with `a` = 61 at cycles 5 and 19 of the conversion → ignored, `d` = 28'h0000524, `nd` = 3. Hold `s` = 1 through the `done` cycle with `a` = 61 → second conversion accepted, `d` = 28'h0000061, `nd` = 2 exactly 20 cycles later.
5. Accept `a` = 999999, assert `c` at iteration 10 → next cycle `busy` = 0, `d` = 0, `nd` = 1, and no `done` for 30 cycles. A new `s` with `a` = 100000 → `d` = 28'h0100000, `nd` = 6.
6. Random regression: 1000 random `a` values → compare each `d` digit against `a / 10^j % 10` and check `nd`.
